// File: rtl/nibble_collector.sv
`default_nettype none
// ============================================================================
// Module   : nibble_collector
// Brief    : Receive side of the nibble-serial word loader. Checks each
//            byte's rdy flag and mode field. Rebuilds two W-bit words from
//            consecutive nibbles, most significant nibble first. Reports a
//            completed frame with a one-cycle valid pulse and an aborted
//            frame with a one-cycle err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_collector #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [7:0]   in_byte,
    output logic [W-1:0] word_a,
    output logic [W-1:0] word_b,
    output logic [2:0]   mode_out,
    output logic         valid,
    output logic         err,
    output logic         busy
);

    localparam int N  = W / 4;
    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RECV_A = 2'd1;
    localparam logic [1:0] c_RECV_B = 2'd2;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_sh;
    logic [W-1:0]  r_a_hold;
    logic [2:0]    r_cur_mode;

    logic [W-1:0]  w_next_sh;
    logic          w_rdy;
    logic          w_good;
    logic          w_last;

    // Shift register contents once the current nibble has been appended.
    // A 4-bit word has no older nibbles to keep.
    if (W > 4) begin : g_shift_wide
        assign w_next_sh = {r_sh[W-5:0], in_byte[3:0]};
    end else begin : g_shift_narrow
        assign w_next_sh = in_byte[3:0];
    end

    assign w_rdy  = in_byte[4];
    assign w_good = w_rdy && (in_byte[7:5] == r_cur_mode);
    // The counter is zero whenever the block is idle. The first nibble of a
    // frame therefore takes the same completion test as later nibbles.
    assign w_last = (r_cnt == c_CNT_LAST);
    assign busy   = (r_state != c_IDLE);

    // Frame FSM: word assembly, the held output frame and the status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_sh       <= '0;
            r_a_hold   <= '0;
            r_cur_mode <= 3'd0;
            word_a     <= '0;
            word_b     <= '0;
            mode_out   <= 3'd0;
            valid      <= 1'b0;
            err        <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (ena) begin
                case (r_state)
                    c_IDLE: begin
                        // A byte with rdy low is line idle, not an error.
                        if (w_rdy) begin
                            r_cur_mode <= in_byte[7:5];
                            r_sh       <= w_next_sh;
                            if (w_last) begin
                                r_a_hold <= w_next_sh;
                                r_cnt    <= '0;
                                r_state  <= c_RECV_B;
                            end else begin
                                r_cnt   <= c_CNT_ONE;
                                r_state <= c_RECV_A;
                            end
                        end
                    end
                    c_RECV_A: begin
                        if (!w_good) begin
                            err     <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= c_IDLE;
                        end else begin
                            r_sh <= w_next_sh;
                            if (w_last) begin
                                r_a_hold <= w_next_sh;
                                r_cnt    <= '0;
                                r_state  <= c_RECV_B;
                            end else begin
                                r_cnt <= r_cnt + c_CNT_ONE;
                            end
                        end
                    end
                    c_RECV_B: begin
                        if (!w_good) begin
                            err     <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= c_IDLE;
                        end else begin
                            r_sh <= w_next_sh;
                            if (w_last) begin
                                word_a   <= r_a_hold;
                                word_b   <= w_next_sh;
                                mode_out <= r_cur_mode;
                                valid    <= 1'b1;
                                r_cnt    <= '0;
                                r_state  <= c_IDLE;
                            end else begin
                                r_cnt <= r_cnt + c_CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        // Unused encoding: recover quietly.
                        r_cnt   <= '0;
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_collector
// Brief    : Self-checking bench for nibble_collector (W=32). Each expected
//            valid or err event is queued when its stimulus is issued. A
//            monitor pops the queue whenever the DUT pulses valid or err.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_collector;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [7:0]  in_byte;
    logic [31:0] word_a;
    logic [31:0] word_b;
    logic [2:0]  mode_out;
    logic        valid;
    logic        err;
    logic        busy;

    int n_checks;
    int n_errors;
    int cyc;
    int valid_cyc_last;
    int valid_cyc_prev;

    typedef struct {
        bit          is_err;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  m;
    } exp_t;

    exp_t q[$];

    // Model of the outputs held from the last good frame.
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [2:0]  m_m;

    nibble_collector #(.W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .in_byte  (in_byte),
        .word_a   (word_a),
        .word_b   (word_b),
        .mode_out (mode_out),
        .valid    (valid),
        .err      (err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare every valid or err pulse against the queue head.
    always @(negedge clk) begin
        if (valid || err) begin
            exp_t e;
            chk("valid_err_exclusive", 32'(valid && err), 32'd0);
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_event: got valid=%0b err=%0b expected none", valid, err);
            end else begin
                e = q.pop_front();
                chk("event_kind_err", 32'(err), 32'(e.is_err));
                chk("word_a", word_a, e.a);
                chk("word_b", word_b, e.b);
                chk("mode_out", 32'(mode_out), 32'(e.m));
                if (valid) begin
                    valid_cyc_prev = valid_cyc_last;
                    valid_cyc_last = cyc;
                end
            end
        end
    end

    // One clock cycle of stimulus. Inputs change just after the edge.
    task automatic cycle(input logic e, input logic [7:0] b);
        ena     = e;
        in_byte = b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] mk(input logic [2:0] m, input logic [3:0] nib);
        return {m, 1'b1, nib};
    endfunction

    function automatic logic [3:0] nib_of(input logic [31:0] a, input logic [31:0] b, input int i);
        logic [63:0] ab;
        ab = {a, b};
        return ab[63 - 4*i -: 4];
    endfunction

    // Full frame. Optional ena=0 gaps after samples 4 and 12. busy is
    // checked after every sample when chk_busy is set.
    task automatic send_frame(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                              input int gap4, input int gap12, input bit chk_busy);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                q.push_back('{is_err: 1'b0, a: a, b: b, m: m});
                m_a = a; m_b = b; m_m = m;
            end
            cycle(1'b1, mk(m, nib_of(a, b, i)));
            if (chk_busy) chk($sformatf("busy_s%0d", i + 1), 32'(busy), (i < 15) ? 32'd1 : 32'd0);
            if (i == 3)  for (int g = 0; g < gap4; g++)  cycle(1'b0, 8'h00);
            if (i == 11) for (int g = 0; g < gap12; g++) cycle(1'b0, 8'h00);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        n_checks = 0; n_errors = 0; cyc = 0;
        valid_cyc_last = 0; valid_cyc_prev = 0;
        m_a = '0; m_b = '0; m_m = '0;
        rst = 1'b1; ena = 1'b0; in_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        chk("rst_word_a", word_a, 32'h0);
        chk("rst_word_b", word_b, 32'h0);
        chk("rst_mode", 32'(mode_out), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Normal frame with busy tracking.
        send_frame(3'd5, 32'h12345678, 32'h9ABCDEF0, 0, 0, 1'b1);
        idle(2);

        // Enable gaps: valid must land 16+4 samples-worth of cycles later.
        t0 = cyc;
        send_frame(3'd5, 32'h12345678, 32'h9ABCDEF0, 3, 1, 1'b0);
        idle(1);
        chk("gap_latency", 32'(valid_cyc_last - t0), 32'd20);
        idle(1);

        // Dropout after five good nibbles of mode 2.
        for (int i = 1; i <= 5; i++) cycle(1'b1, mk(3'd2, 4'(i)));
        q.push_back('{is_err: 1'b1, a: m_a, b: m_b, m: m_m});
        cycle(1'b1, 8'h00);
        chk("dropout_busy", 32'(busy), 32'd0);
        idle(1);
        chk("dropout_hold_a", word_a, 32'h12345678);
        send_frame(3'd2, 32'hCAFEF00D, 32'h01234567, 0, 0, 1'b0);
        idle(2);

        // Mode change: the offending 0xF4 must not start a frame.
        for (int i = 0; i < 10; i++) cycle(1'b1, mk(3'd3, 4'(i)));
        q.push_back('{is_err: 1'b1, a: m_a, b: m_b, m: m_m});
        cycle(1'b1, 8'hF4);
        chk("modechg_busy", 32'(busy), 32'd0);
        cycle(1'b1, 8'h00);
        chk("modechg_idle_busy", 32'(busy), 32'd0);
        send_frame(3'd7, 32'hDEADBEEF, 32'h55AA55AA, 0, 0, 1'b0);
        idle(2);

        // Reset mid-frame. rst wins over a concurrent sample.
        for (int i = 0; i < 9; i++) cycle(1'b1, mk(3'd4, 4'(15 - i)));
        rst = 1'b1;
        cycle(1'b1, mk(3'd4, 4'h6));
        rst = 1'b0;
        m_a = '0; m_b = '0; m_m = '0;
        chk("midrst_word_a", word_a, 32'h0);
        chk("midrst_word_b", word_b, 32'h0);
        chk("midrst_mode", 32'(mode_out), 32'h0);
        chk("midrst_valid", 32'(valid), 32'h0);
        chk("midrst_err", 32'(err), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        send_frame(3'd4, 32'hA5A5A5A5, 32'h3C3C3C3C, 0, 0, 1'b0);
        idle(2);

        // Back-to-back frames with no gap.
        send_frame(3'd1, 32'hFFFFFFFF, 32'h00000000, 0, 0, 1'b0);
        send_frame(3'd6, 32'h0F0F0F0F, 32'hF0F0F0F0, 0, 0, 1'b0);
        idle(2);
        chk("b2b_spacing", 32'(valid_cyc_last - valid_cyc_prev), 32'd16);

        idle(4);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nibble_collector.md
# nibble_collector

Receive-side counterpart of the nibble-serial word loader. It samples the 8-bit frame stream, checks the per-byte ready flag and the mode field, and reassembles two W-bit words from consecutive nibbles, most significant nibble first. It delivers a completed frame with a one-cycle valid pulse, and sits at the consuming end of the loader link ahead of the watchdog command logic.

## Interface
- W, default 32: word width; must be a multiple of 4. Each word is N = W/4 nibbles.

- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- ena  in  1  sample enable. Cycles with ena=0 are ignored entirely.
- in_byte  in  8  frame byte: [7:5] mode, [4] rdy, [3:0] nibble.
- word_a  out  W  first word of the last good frame.
- word_b  out  W  second word of the last good frame.
- mode_out  out  3  mode of the last good frame.
- valid  out  1  one-cycle pulse when a frame has completed.
- err  out  1  one-cycle pulse when a frame is aborted.
- busy  out  1  high while a frame is in progress.

## Operation
- Clocking and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, nibble count=0, shift register=0, held copy of A=0, captured mode=0. All outputs reset to 0.
- Sample: a rising edge with ena=1. Sample-free edges leave all state and held outputs unchanged, except that valid and err drop to 0.
- busy is combinational: busy = (state != IDLE).
- Shift register: sh <= {sh[W-5:0], in_byte[3:0]}, so the first received nibble ends up in word bits [W-1:W-4].

States:
- IDLE
  - Sample with in_byte[4]=1: capture cur_mode = in_byte[7:5], shift in the nibble, cnt=1, go to RECV_A.
  - Sample with in_byte[4]=0: stay in IDLE. This is line idle, not an error.
- RECV_A
  - Sample with in_byte[4]=0: pulse err, go to IDLE.
  - Sample with in_byte[4]=1 and in_byte[7:5] != cur_mode: pulse err, go to IDLE.
  - Otherwise shift in the nibble and increment cnt. On reaching cnt=N, copy the completed word to a_hold, clear cnt, and go to RECV_B.
- RECV_B
  - Same checks as RECV_A.
  - On the Nth good nibble: word_a <= a_hold, word_b <= completed word, mode_out <= cur_mode, pulse valid, go to IDLE.
- Aborted frame: word_a, word_b and mode_out keep the previous good frame. Partial data is discarded, and the byte that caused the abort is not reused as a frame start.
- Output holding: the outputs change only on valid or on reset.
- Width of cnt: $clog2(N)+1 bits. cnt never exceeds N.
- Unreachable state encoding: goes to IDLE, with no err pulse.

## Timing
- Frame length: exactly 2N good samples (16 for W=32). ena=0 gaps of any length inside a frame are allowed.
- Latency: valid, word_a, word_b and mode_out update on the edge that samples the last nibble of B, so they are visible the following cycle. valid is high for exactly one cycle.
- err: pulses high for one cycle, registered on the edge that samples the offending byte.
- Back-to-back frames: a rdy byte sampled in the cycle immediately after the valid pulse starts a new frame. There is no dead cycle.
- Simultaneous events:
  - rst=1 wins over everything, including ena, a completing frame, or an error.
  - Reset mid-frame clears the partial frame with no err pulse and no valid pulse, and clears the held outputs to 0.
- valid and err are never high in the same cycle.

## Test plan
- Normal frame:
  - Stimulus: W=32, mode=5, A=0x12345678, B=0x9ABCDEF0. Drive 16 bytes with ena=1: 0xB1,0xB2,…,0xB8, then 0xB9,0xBA,…,0xBF,0xB0.
  - Required response: valid for one cycle; word_a=0x12345678, word_b=0x9ABCDEF0, mode_out=5. busy is high from sample 1 through sample 16 and low afterwards.
- Enable gaps:
  - Stimulus: the same frame with ena=0 for 3 cycles after sample 4 and for 1 cycle after sample 12. During the ena=0 cycles in_byte is driven to 0x00.
  - Required response: the same words as the normal frame, with valid delayed by 4 cycles; no err.
- Dropout:
  - Stimulus: five good bytes of mode 2 (0x51..0x55), then 0x00 with ena=1.
  - Required response: err pulses; busy goes to 0; word_a, word_b and mode_out keep their previous values. A full frame that follows is received correctly.
- Mode change:
  - Stimulus: mode=3 bytes for 10 nibbles, then 0xF4 (mode 7, rdy=1).
  - Required response: err pulses and the block returns to IDLE. 0xF4 does not start a new frame, and no valid follows until a fresh 16-byte frame is sent.
- Reset mid-frame:
  - Stimulus: after a good frame, send 9 nibbles of a new frame, then assert rst for 1 cycle.
  - Required response: all outputs are 0 and busy=0; no err and no valid. A following full frame is received correctly.
- Back-to-back:
  - Stimulus: two 16-byte frames with no gap, (A=0xFFFFFFFF, B=0x00000000, mode 1) then (A=0x0F0F0F0F, B=0xF0F0F0F0, mode 6).
  - Required response: two valid pulses 16 cycles apart, each carrying the correct words and mode.
